// File: rtl/cxa_pkg.sv
// Shared level codes and FSM state encoding for the tank fill controller.
package cxa_pkg;

    localparam int unsigned LVL_W = 2;

    // Level codes as {Nv1, Nv0}
    localparam logic [LVL_W-1:0] LVL_EMPTY   = 2'b00;
    localparam logic [LVL_W-1:0] LVL_LOW     = 2'b01;
    localparam logic [LVL_W-1:0] LVL_FULL    = 2'b11;
    localparam logic [LVL_W-1:0] LVL_INVALID = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        FAULT = 2'd2,
        REST  = 2'd3
    } cxa_state_t;

endpackage

// File: rtl/cxa_debounce.sv
// Single-bit sensor debouncer: accepts a new value only after it has been
// sampled DEB_CYCLES consecutive times; done_once marks the first full window.
module cxa_debounce #(
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic raw,
    output logic stable,
    output logic done_once
);

    localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);

    logic             prev;
    logic [CNT_W-1:0] cnt;

    // cnt = number of consecutive identical samples, saturating at DEB_CYCLES
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            prev      <= 1'b0;
            cnt       <= '0;
            stable    <= 1'b0;
            done_once <= 1'b0;
        end else begin
            prev <= raw;
            if (raw != prev) begin
                cnt <= CNT_W'(1);
            end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
                cnt       <= CNT_W'(DEB_CYCLES);
                stable    <= raw;
                done_once <= 1'b1;
            end else if (cnt != CNT_W'(DEB_CYCLES)) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/cxa_fill_ctrl.sv
// Tank fill controller: debounced level sensing, pump hysteresis (start on
// EMPTY, stop on FULL), fill timeout, sensor-fault alarm and valve gating.
// Optional feature macro CXA_MIN_OFF_EN adds a REST state that enforces a
// minimum pump-off time of MIN_OFF cycles after a completed fill.
module cxa_fill_ctrl
    import cxa_pkg::*;
#(
    parameter int unsigned DEB_CYCLES   = 16,
    parameter int unsigned FILL_TIMEOUT = 1000000,
    parameter int unsigned MIN_OFF      = 50000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       Nv1,
    input  logic       Nv0,
    input  logic       IRR_REQ,
    input  logic       CLR,
    output logic [1:0] LVL_OUT,
    output logic       BOMBA,
    output logic       VALV,
    output logic       ALARM,
    output logic [1:0] STATE
);

    localparam int unsigned TMR_W = $clog2(FILL_TIMEOUT + 1);
`ifdef CXA_MIN_OFF_EN
    localparam int unsigned REST_W = $clog2(MIN_OFF + 1);
`endif

    // Elaboration-time parameter sanity checks
    if (DEB_CYCLES < 2) begin : g_deb_chk
        $error("DEB_CYCLES must be at least 2");
    end
    if (FILL_TIMEOUT < 1) begin : g_tmo_chk
        $error("FILL_TIMEOUT must be at least 1");
    end
    if (MIN_OFF < 1) begin : g_off_chk
        $error("MIN_OFF must be at least 1");
    end

    logic             lvl1;
    logic             lvl0;
    logic             done1;
    logic             done0;
    logic             primed;
    logic [LVL_W-1:0] lvl;
    logic             clr_q;

    cxa_state_t       state_q;
    cxa_state_t       state_nxt;
    logic [TMR_W-1:0] timer_q;
    logic [TMR_W-1:0] timer_nxt;
`ifdef CXA_MIN_OFF_EN
    logic [REST_W-1:0] rest_q;
    logic [REST_W-1:0] rest_nxt;
`endif

    cxa_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_nv1 (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .raw       (Nv1),
        .stable    (lvl1),
        .done_once (done1)
    );

    cxa_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_nv0 (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .raw       (Nv0),
        .stable    (lvl0),
        .done_once (done0)
    );

    assign lvl     = {lvl1, lvl0};
    assign primed  = done1 & done0;
    assign LVL_OUT = lvl;
    assign STATE   = state_q;

    // Next-state logic; nothing moves until both sensors have been primed
    always_comb begin
        state_nxt = state_q;
        timer_nxt = timer_q;
`ifdef CXA_MIN_OFF_EN
        rest_nxt  = rest_q;
`endif
        if (primed) begin
            case (state_q)
                IDLE: begin
                    if (lvl == LVL_EMPTY) begin
                        state_nxt = FILL;
                        timer_nxt = '0;
                    end else if (lvl == LVL_INVALID) begin
                        state_nxt = FAULT;
                    end
                end
                FILL: begin
                    if (lvl == LVL_INVALID) begin
                        state_nxt = FAULT;
                    end else if (lvl == LVL_FULL) begin
`ifdef CXA_MIN_OFF_EN
                        state_nxt = REST;
                        rest_nxt  = '0;
`else
                        state_nxt = IDLE;
`endif
                    end else if (timer_q == TMR_W'(FILL_TIMEOUT - 1)) begin
                        state_nxt = FAULT;
                    end else begin
                        timer_nxt = timer_q + TMR_W'(1);
                    end
                end
                FAULT: begin
                    if (clr_q && (lvl != LVL_INVALID)) begin
                        state_nxt = IDLE;
                    end
                end
`ifdef CXA_MIN_OFF_EN
                REST: begin
                    if (lvl == LVL_INVALID) begin
                        state_nxt = FAULT;
                    end else if (rest_q == REST_W'(MIN_OFF - 1)) begin
                        state_nxt = IDLE;
                    end else begin
                        rest_nxt = rest_q + REST_W'(1);
                    end
                end
`endif
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State, counters, captured clear pulse and registered outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            timer_q <= '0;
`ifdef CXA_MIN_OFF_EN
            rest_q  <= '0;
`endif
            clr_q   <= 1'b0;
            BOMBA   <= 1'b0;
            ALARM   <= 1'b0;
            VALV    <= 1'b0;
        end else begin
            state_q <= state_nxt;
            timer_q <= timer_nxt;
`ifdef CXA_MIN_OFF_EN
            rest_q  <= rest_nxt;
`endif
            clr_q   <= CLR;
            BOMBA   <= (state_nxt == FILL);
            ALARM   <= (state_nxt == FAULT);
            VALV    <= IRR_REQ & primed & (lvl != LVL_EMPTY)
                       & (lvl != LVL_INVALID) & (state_q != FAULT);
        end
    end

endmodule

// File: tb/tb_cxa_fill_ctrl.sv
// Bench for cxa_fill_ctrl: a window/queue-based reference model checked on
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_cxa_fill_ctrl;

    localparam int unsigned DEB = 4;
    localparam int unsigned FT  = 20;
    localparam int unsigned MO  = 8;
`ifdef CXA_MIN_OFF_EN
    localparam bit MIN_OFF_EN = 1'b1;
`else
    localparam bit MIN_OFF_EN = 1'b0;
`endif
    localparam int S_IDLE = 0, S_FILL = 1, S_FAULT = 2, S_REST = 3;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       Nv1 = 1'b0;
    logic       Nv0 = 1'b0;
    logic       IRR_REQ = 1'b0;
    logic       CLR = 1'b0;
    logic [1:0] LVL_OUT;
    logic       BOMBA;
    logic       VALV;
    logic       ALARM;
    logic [1:0] STATE;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 CLK = ~CLK;

    cxa_fill_ctrl #(
        .DEB_CYCLES   (DEB),
        .FILL_TIMEOUT (FT),
        .MIN_OFF      (MO)
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .Nv1     (Nv1),
        .Nv0     (Nv0),
        .IRR_REQ (IRR_REQ),
        .CLR     (CLR),
        .LVL_OUT (LVL_OUT),
        .BOMBA   (BOMBA),
        .VALV    (VALV),
        .ALARM   (ALARM),
        .STATE   (STATE)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_raw(input logic [1:0] v);
        Nv1 = v[1];
        Nv0 = v[0];
    endtask

    // Reference model: a bit is accepted when the last DEB raw samples agree;
    // the pump runs from EMPTY to FULL, faulting after FT pump-on cycles.
    int h1[$];
    int h0[$];
    int m_b1, m_b0, m_d1, m_d0, m_clr, m_state, m_on, m_rest;
    int m_bomba, m_alarm, m_valv;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            h1.delete();
            h0.delete();
            m_b1 = 0; m_b0 = 0; m_d1 = 0; m_d0 = 0; m_clr = 0;
            m_state = S_IDLE; m_on = 0; m_rest = 0;
            m_bomba = 0; m_alarm = 0; m_valv = 0;
        end else begin : mdl
            int lvl;
            int primed;
            int ns;
            bit u1;
            bit u0;
            lvl    = m_b1 * 2 + m_b0;
            primed = m_d1 & m_d0;
            ns     = m_state;
            m_valv = (IRR_REQ && primed != 0 && lvl != 0 && lvl != 2 && m_state != S_FAULT) ? 1 : 0;
            if (primed != 0) begin
                if (m_state == S_IDLE) begin
                    if (lvl == 0) begin
                        ns   = S_FILL;
                        m_on = 0;
                    end else if (lvl == 2) begin
                        ns = S_FAULT;
                    end
                end else if (m_state == S_FILL) begin
                    m_on++;
                    if (lvl == 2) ns = S_FAULT;
                    else if (lvl == 3) begin
                        ns     = MIN_OFF_EN ? S_REST : S_IDLE;
                        m_rest = 0;
                    end else if (m_on == FT) ns = S_FAULT;
                end else if (m_state == S_FAULT) begin
                    if (m_clr != 0 && lvl != 2) ns = S_IDLE;
                end else begin
                    m_rest++;
                    if (lvl == 2) ns = S_FAULT;
                    else if (m_rest == MO) ns = S_IDLE;
                end
            end
            m_state = ns;
            m_bomba = (ns == S_FILL) ? 1 : 0;
            m_alarm = (ns == S_FAULT) ? 1 : 0;
            h1.push_back(int'(Nv1));
            h0.push_back(int'(Nv0));
            if (h1.size() > DEB) void'(h1.pop_front());
            if (h0.size() > DEB) void'(h0.pop_front());
            if (h1.size() == DEB) begin
                u1 = 1'b1;
                foreach (h1[i]) if (h1[i] != h1[0]) u1 = 1'b0;
                if (u1) begin m_b1 = h1[0]; m_d1 = 1; end
            end
            if (h0.size() == DEB) begin
                u0 = 1'b1;
                foreach (h0[i]) if (h0[i] != h0[0]) u0 = 1'b0;
                if (u0) begin m_b0 = h0[0]; m_d0 = 1; end
            end
            m_clr = int'(CLR);
        end
    end

    // Cycle-by-cycle comparison against the model, just after each edge
    always @(posedge CLK) begin
        #1;
        if (RST_N && chk_en) begin
            check("mdl_lvl",   int'(LVL_OUT), m_b1 * 2 + m_b0);
            check("mdl_bomba", int'(BOMBA),   m_bomba);
            check("mdl_alarm", int'(ALARM),   m_alarm);
            check("mdl_valv",  int'(VALV),    m_valv);
            check("mdl_state", int'(STATE),   m_state);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        repeat (2) @(negedge CLK);
        check("rst_lvl",   int'(LVL_OUT), 0);
        check("rst_bomba", int'(BOMBA),   0);
        check("rst_valv",  int'(VALV),    0);
        check("rst_alarm", int'(ALARM),   0);
        check("rst_state", int'(STATE),   0);
        RST_N  = 1'b1;
        chk_en = 1'b1;

        // Priming on EMPTY: primed at edge 4, pump on at edge 5
        repeat (4) @(negedge CLK);
        check("prime_bomba_off", int'(BOMBA), 0);
        @(negedge CLK);
        check("prime_bomba_on", int'(BOMBA), 1);
        check("prime_state", int'(STATE), 1);

        // Hysteresis: LOW keeps filling, FULL stops five cycles later
        set_raw(2'b01);
        repeat (10) begin
            @(negedge CLK);
            check("hyst_bomba", int'(BOMBA), 1);
        end
        set_raw(2'b11);
        repeat (4) @(negedge CLK);
        check("full_bomba_still", int'(BOMBA), 1);
        @(negedge CLK);
        check("full_bomba_off", int'(BOMBA), 0);
        check("full_state", int'(STATE), MIN_OFF_EN ? 3 : 0);

        // Empty again straight away: restart gap depends on REST
        set_raw(2'b00);
        k = 0;
        while (k < 30) begin
            @(negedge CLK);
            k++;
            if (BOMBA) break;
        end
        check("restart_gap", k, MIN_OFF_EN ? 9 : 5);

        // Fill timeout: pump high exactly FT cycles, then alarm
        k = 1;
        while (k < 40) begin
            @(negedge CLK);
            if (!BOMBA) break;
            k++;
        end
        check("timeout_on_cycles", k, 20);
        check("timeout_alarm", int'(ALARM), 1);
        check("timeout_state", int'(STATE), 2);

        // Clear with EMPTY: IDLE one cycle after capture, refill the next
        CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
        check("clr_capture_alarm", int'(ALARM), 1);
        @(negedge CLK);
        check("clr_alarm", int'(ALARM), 0);
        check("clr_state", int'(STATE), 0);
        check("clr_bomba", int'(BOMBA), 0);
        @(negedge CLK);
        check("clr_refill", int'(BOMBA), 1);

        // INVALID during fill faults; clear ignored while INVALID
        set_raw(2'b10);
        repeat (4) @(negedge CLK);
        check("inv_lvl", int'(LVL_OUT), 2);
        check("inv_bomba_pre", int'(BOMBA), 1);
        @(negedge CLK);
        check("inv_state", int'(STATE), 2);
        check("inv_bomba", int'(BOMBA), 0);
        CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
        repeat (3) @(negedge CLK);
        check("inv_clr_ignored", int'(ALARM), 1);
        check("inv_clr_state", int'(STATE), 2);
        set_raw(2'b11);
        repeat (5) @(negedge CLK);
        CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
        @(negedge CLK);
        check("inv_clr_ok_alarm", int'(ALARM), 0);
        check("inv_clr_ok_state", int'(STATE), 0);
        repeat (3) begin
            @(negedge CLK);
            check("full_idle_bomba", int'(BOMBA), 0);
        end

        // Glitch of DEB-1 cycles never reaches LVL_OUT
        set_raw(2'b00);
        repeat (3) begin
            @(negedge CLK);
            check("glitch_lvl", int'(LVL_OUT), 3);
        end
        set_raw(2'b11);
        repeat (6) begin
            @(negedge CLK);
            check("glitch_lvl_after", int'(LVL_OUT), 3);
            check("glitch_bomba", int'(BOMBA), 0);
        end

        // Valve gating
        set_raw(2'b01);
        repeat (5) @(negedge CLK);
        check("low_idle_lvl", int'(LVL_OUT), 1);
        check("low_idle_bomba", int'(BOMBA), 0);
        check("valv_idle_off", int'(VALV), 0);
        IRR_REQ = 1'b1;
        @(negedge CLK);
        check("valv_on", int'(VALV), 1);
        set_raw(2'b00);
        repeat (4) @(negedge CLK);
        check("valv_lag", int'(VALV), 1);
        @(negedge CLK);
        check("valv_empty_off", int'(VALV), 0);
        check("empty_fill", int'(BOMBA), 1);
        set_raw(2'b01);
        repeat (5) @(negedge CLK);
        check("valv_during_fill", int'(VALV), 1);
        check("bomba_low_fill", int'(BOMBA), 1);
        k = 0;
        while (k < 40 && !ALARM) begin
            @(negedge CLK);
            k++;
        end
        check("valv_fault_alarm", int'(ALARM), 1);
        @(negedge CLK);
        check("valv_fault_off", int'(VALV), 0);

        // Asynchronous reset mid-fill, then priming must be re-earned
        CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
        @(negedge CLK);
        check("pre_rst_state", int'(STATE), 0);
        set_raw(2'b00);
        repeat (5) @(negedge CLK);
        check("pre_rst_bomba", int'(BOMBA), 1);
        #2;
        RST_N = 1'b0;
        #1;
        check("async_rst_bomba", int'(BOMBA), 0);
        check("async_rst_state", int'(STATE), 0);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (4) @(negedge CLK);
        check("reprime_bomba_off", int'(BOMBA), 0);
        @(negedge CLK);
        check("reprime_bomba_on", int'(BOMBA), 1);

        IRR_REQ = 1'b0;
        repeat (2) @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
